if_stage_bp: RTL and testbench
==============================

# if_stage_bp

Parametrised instruction-fetch stage with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It drives the instruction-memory/BIOS fetch address and selects the next PC by priority: writeback flush, then execute redirect, then stall, then BTB-predicted target, then PC+4. It registers the fetched PC, instruction-source select, valid bit and prediction into the ID pipeline registers. EX compares the registered prediction against the resolved branch and feeds both corrections and training updates back.

## Interface
- RESET_PC, 32'h4000_0000, PC loaded on reset
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX = log2(BTB_ENTRIES)
- CTR_INIT, 2'b01, counter value after reset (weakly not-taken)
- BP_EN, 1, 0 disables prediction and BTB training; BTB stays at reset contents
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (reset when rst==0 at a rising edge)
- id_stall  in  1  hold PC and ID registers
- ex_redirect  in  1  EX resolved a mispredict or jump; fetch from ex_redirect_pc
- ex_redirect_pc  in  32  corrected PC
- ex_br_valid  in  1  EX resolved a control-flow instruction this cycle (train BTB)
- ex_br_pc  in  32  PC of that instruction
- ex_br_taken  in  1  resolved direction
- ex_br_target  in  32  resolved taken target
- wb_flush  in  1  WB redirect, highest priority
- wb_alu  in  32  WB redirect PC
- if_addr  out  32  current fetch PC, combinational from PC register
- if_bios_en  out  1  if_addr[30]
- id_pc  out  32  registered fetch PC
- id_inst_sel  out  2  `INST_BIOS if PC[30], else `INST_IMEM (control_sel.vh)
- id_valid  out  1  0 marks a bubble in ID
- id_pred_taken  out  1  fetch was redirected by the BTB
- id_pred_target  out  32  predicted target; 0 when not predicted

## Operation
- BTB entry: valid, tag = PC[31:IDX+2], target[31:0], ctr[1:0]; index = PC[IDX+1:2].
- Lookup (combinational on if_addr): hit = valid & tag match; pred = BP_EN & hit & ctr[1].
- Next PC priority: !rst → RESET_PC; wb_flush → wb_alu; ex_redirect → ex_redirect_pc; id_stall → hold; pred → BTB target; else if_addr+4 (mod 2^32, wraps).
- ID register write enable: !id_stall | wb_flush | ex_redirect.
  - On write, load id_pc = if_addr and id_inst_sel from if_addr[30]. id_pred_* load from the lookup.
  - id_valid loads 1, except 0 when wb_flush or ex_redirect is high.
- Training, when BP_EN & ex_br_valid, independent of stall or flush:
  - Taken and hit: ctr saturating +1 (max 3); target updated.
  - Taken and miss: allocate (valid=1, tag, target); ctr=2'b10, overwriting any alias.
  - Not taken and hit: ctr saturating −1 (min 0).
  - Not taken and miss: no change.
- Same-cycle lookup and training of one index: the lookup sees pre-update contents; the write is visible next cycle.
- Reset:
  - All BTB valid bits cleared and all ctr set to CTR_INIT in the same edge. Targets and tags are don't-care.
  - PC=RESET_PC; id_pc=0, id_inst_sel=`INST_IMEM, id_valid=0, id_pred_taken=0, id_pred_target=0.
  - Reset mid-operation overrides all redirects and updates in that cycle.

## Timing
- if_addr and if_bios_en change only at clock edges (PC register output).
- Redirect latency: 1 cycle. The redirect PC appears on if_addr the cycle after wb_flush or ex_redirect is sampled.
- Predicted fetch: target appears on if_addr the cycle after the predicting PC.
- ID outputs are 1 cycle behind if_addr.
- Stall with redirect: the redirect wins; PC and ID registers both load, and id_valid=0.
- BTB training is visible to lookups starting 1 cycle after ex_br_valid.

## Test plan
- Reset with rst=0 for 2 cycles, then release -> if_addr=0x4000_0000, if_bios_en=1; next cycles 0x4000_0004, 0x4000_0008; first id_valid=1 with id_inst_sel=`INST_BIOS.
- Train ex_br_pc=0x1000_0010, taken, ex_br_target=0x1000_0000, once -> next fetch of 0x1000_0010 is followed by if_addr=0x1000_0000, id_pred_taken=1, id_pred_target=0x1000_0000.
- Two not-taken trainings on the entry from the previous scenario -> ctr 2→1→0; fetch of 0x1000_0010 goes to 0x1000_0014 with id_pred_taken=0. Four taken trainings saturate ctr at 3.
- Alias: train 0x1000_0010 taken, then fetch 0x1000_0050 (same index, BTB_ENTRIES=16) -> tag miss, next PC 0x1000_0054.
- id_stall=1 with ex_redirect=1 (0x1000_0100) and wb_flush=1 (0x4000_0200) in the same cycle -> next if_addr=0x4000_0200, id_valid=0.
- BP_EN=0 build, repeat the training scenario -> never predicts; sequential PC+4 throughout. Also: PC 0xFFFF_FFFC with no redirect wraps to 0x0000_0000.

Source files
------------

// File: rtl/if_stage_bp.sv
// ----------------------------------------------------------------------------
// if_stage_bp
//
// Instruction-fetch stage with a direct-mapped branch target buffer (BTB) and
// 2-bit saturating direction counters.
//
// The PC register drives the instruction-memory/BIOS fetch address directly.
// The next PC is chosen in this priority order:
//   1. WB flush
//   2. EX redirect
//   3. stall (hold)
//   4. BTB-predicted target
//   5. PC+4
//
// The fetched PC, the instruction-source select, a valid bit and the
// prediction are registered into the ID pipeline registers. EX resolves
// branches and feeds training updates back through the ex_br_* port group.
//
// Parameters:
//   RESET_PC    - PC loaded on reset
//   BTB_ENTRIES - BTB depth, power of two, at least 2
//   CTR_INIT    - direction counter value after reset
//   BP_EN       - 0 disables prediction and BTB training
//
// Ports:
//   clk, rst                  - clock; synchronous active-low reset
//   id_stall                  - hold PC and ID registers
//   ex_redirect/_pc           - EX correction (mispredict or jump)
//   ex_br_valid/_pc/_taken/_target
//                             - EX resolved control flow, trains the BTB
//   wb_flush, wb_alu          - WB redirect, highest priority
//   if_addr, if_bios_en       - current fetch PC and its BIOS-region bit
//   id_pc, id_inst_sel, id_valid,
//   id_pred_taken, id_pred_target
//                             - ID pipeline registers
// ----------------------------------------------------------------------------
module if_stage_bp #(
  parameter logic [31:0] RESET_PC    = 32'h4000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter logic [1:0]  CTR_INIT    = 2'b01,
  parameter bit          BP_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic        ex_br_valid,
  input  logic [31:0] ex_br_pc,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic        wb_flush,
  input  logic [31:0] wb_alu,
  output logic [31:0] if_addr,
  output logic        if_bios_en,
  output logic [31:0] id_pc,
  output logic [1:0]  id_inst_sel,
  output logic        id_valid,
  output logic        id_pred_taken,
  output logic [31:0] id_pred_target
);

  // Instruction-source select encodings (match control_sel.vh).
  localparam logic [1:0] INST_BIOS = 2'b00;
  localparam logic [1:0] INST_IMEM = 2'b01;

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;

  // --------------------------------------------------------------------------
  // BTB storage
  //
  // Only the valid bits and the counters have a defined reset value. Tags and
  // targets are always qualified by the valid bit, so they need no reset.
  // --------------------------------------------------------------------------
  logic             btb_valid  [BTB_ENTRIES];
  logic [1:0]       btb_ctr    [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]      btb_target [BTB_ENTRIES];

  logic [31:0] pc;
  logic [31:0] pc_next;

  assign if_addr    = pc;
  assign if_bios_en = pc[30];

  // --------------------------------------------------------------------------
  // Lookup on the current fetch PC
  // --------------------------------------------------------------------------
  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_pred;
  logic [31:0]      lk_target;

  assign lk_idx    = pc[IDX+1:2];
  assign lk_tag    = pc[31:IDX+2];
  assign lk_hit    = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign lk_pred   = BP_EN && lk_hit && btb_ctr[lk_idx][1];
  assign lk_target = btb_target[lk_idx];

  // --------------------------------------------------------------------------
  // Next-PC selection
  // --------------------------------------------------------------------------
  always_comb begin
    pc_next = pc + 32'd4;
    if (wb_flush) begin
      pc_next = wb_alu;
    end else if (ex_redirect) begin
      pc_next = ex_redirect_pc;
    end else if (id_stall) begin
      pc_next = pc;
    end else if (lk_pred) begin
      pc_next = lk_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // --------------------------------------------------------------------------
  // ID pipeline registers
  //
  // A redirect overrides a stall: the wrong-path fetch still loads, but it is
  // marked as a bubble.
  // --------------------------------------------------------------------------
  logic id_we;

  assign id_we = !id_stall || wb_flush || ex_redirect;

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_pc          <= 32'h0;
      id_inst_sel    <= INST_IMEM;
      id_valid       <= 1'b0;
      id_pred_taken  <= 1'b0;
      id_pred_target <= 32'h0;
    end else if (id_we) begin
      id_pc          <= pc;
      id_inst_sel    <= pc[30] ? INST_BIOS : INST_IMEM;
      id_valid       <= !(wb_flush || ex_redirect);
      id_pred_taken  <= lk_pred;
      id_pred_target <= lk_pred ? lk_target : 32'h0;
    end
  end

  // --------------------------------------------------------------------------
  // Training from EX
  //
  // Training ignores stall and flush: the branch has already resolved, so its
  // outcome is always recorded.
  // --------------------------------------------------------------------------
  logic [IDX-1:0]   tr_idx;
  logic [TAG_W-1:0] tr_tag;
  logic             tr_hit;
  logic             tr_en;
  logic [1:0]       tr_ctr;
  logic [1:0]       ctr_inc;
  logic [1:0]       ctr_dec;

  assign tr_idx = ex_br_pc[IDX+1:2];
  assign tr_tag = ex_br_pc[31:IDX+2];
  assign tr_hit = btb_valid[tr_idx] && (btb_tag[tr_idx] == tr_tag);
  assign tr_en  = BP_EN && ex_br_valid;
  assign tr_ctr = btb_ctr[tr_idx];

  always_comb begin
    ctr_inc = (tr_ctr == 2'b11) ? 2'b11 : tr_ctr + 2'b01;
    ctr_dec = (tr_ctr == 2'b00) ? 2'b00 : tr_ctr - 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= CTR_INIT;
      end
    end else if (tr_en) begin
      if (ex_br_taken) begin
        // On a taken miss, allocate over any alias and start weakly taken.
        btb_valid[tr_idx] <= 1'b1;
        btb_ctr[tr_idx]   <= tr_hit ? ctr_inc : 2'b10;
      end else if (tr_hit) begin
        btb_ctr[tr_idx] <= ctr_dec;
      end
    end
  end

  // Tag and target are written on every taken training. On a hit the tag is
  // rewritten with the same value.
  always_ff @(posedge clk) begin
    if (rst && tr_en && ex_br_taken) begin
      btb_tag[tr_idx]    <= tr_tag;
      btb_target[tr_idx] <= ex_br_target;
    end
  end

  // Instructions are word aligned, so the low address bits never index the
  // BTB.
  logic unused_br_pc_lsb;
  assign unused_br_pc_lsb = ^ex_br_pc[1:0];

endmodule

// File: tb/tb_if_stage_bp.sv
module tb_if_stage_bp;

  localparam logic [31:0] RESET_PC  = 32'h4000_0000;
  localparam logic [1:0]  INST_BIOS = 2'b00;
  localparam logic [1:0]  INST_IMEM = 2'b01;
  localparam int          NENT      = 16;
  localparam int          CTR_INIT  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        ex_br_valid;
  logic [31:0] ex_br_pc;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        wb_flush;
  logic [31:0] wb_alu;

  // _p: prediction enabled, _n: BP_EN=0 build
  logic [31:0] if_addr_p, id_pc_p, id_pred_target_p;
  logic        if_bios_en_p, id_valid_p, id_pred_taken_p;
  logic [1:0]  id_inst_sel_p;
  logic [31:0] if_addr_n, id_pc_n, id_pred_target_n;
  logic        if_bios_en_n, id_valid_n, id_pred_taken_n;
  logic [1:0]  id_inst_sel_n;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  if_stage_bp #(
    .RESET_PC   (RESET_PC),
    .BTB_ENTRIES(NENT),
    .CTR_INIT   (2'b01),
    .BP_EN      (1'b1)
  ) dut (
    .clk(clk), .rst(rst), .id_stall(id_stall),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .ex_br_valid(ex_br_valid), .ex_br_pc(ex_br_pc), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target), .wb_flush(wb_flush), .wb_alu(wb_alu),
    .if_addr(if_addr_p), .if_bios_en(if_bios_en_p), .id_pc(id_pc_p),
    .id_inst_sel(id_inst_sel_p), .id_valid(id_valid_p),
    .id_pred_taken(id_pred_taken_p), .id_pred_target(id_pred_target_p)
  );

  if_stage_bp #(
    .RESET_PC   (RESET_PC),
    .BTB_ENTRIES(NENT),
    .CTR_INIT   (2'b01),
    .BP_EN      (1'b0)
  ) dut_nobp (
    .clk(clk), .rst(rst), .id_stall(id_stall),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .ex_br_valid(ex_br_valid), .ex_br_pc(ex_br_pc), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target), .wb_flush(wb_flush), .wb_alu(wb_alu),
    .if_addr(if_addr_n), .if_bios_en(if_bios_en_n), .id_pc(id_pc_n),
    .id_inst_sel(id_inst_sel_n), .id_valid(id_valid_n),
    .id_pred_taken(id_pred_taken_n), .id_pred_target(id_pred_target_n)
  );

  // Reference model; index [0] has prediction on, [1] has it off.
  bit          m_valid  [2][NENT];
  logic [31:0] m_tag    [2][NENT];
  logic [31:0] m_tgt    [2][NENT];
  int          m_ctr    [2][NENT];
  logic [31:0] m_pc     [2];
  logic [31:0] m_id_pc  [2];
  logic [31:0] m_id_tgt [2];
  logic [1:0]  m_id_sel [2];
  bit          m_id_valid [2];
  bit          m_id_pt    [2];

  function automatic logic [31:0] w(input logic x);
    return {31'b0, x};
  endfunction

  function automatic bit in_bios(input logic [31:0] a);
    return (a & 32'h4000_0000) != 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one clock of the rules to the model, using the inputs sampled at
  // the edge that just happened.
  task automatic model_step();
    for (int b = 0; b < 2; b++) begin
      int          li, ti;
      bit          bp, hit, pred, thit;
      logic [31:0] npc;
      bp   = (b == 0);
      li   = int'((m_pc[b] / 4) % NENT);
      hit  = m_valid[b][li] && (m_tag[b][li] == m_pc[b] / (4 * NENT));
      pred = bp && hit && (m_ctr[b][li] >= 2);
      if (!rst) begin
        m_pc[b]       = RESET_PC;
        m_id_pc[b]    = 32'h0;
        m_id_sel[b]   = INST_IMEM;
        m_id_valid[b] = 1'b0;
        m_id_pt[b]    = 1'b0;
        m_id_tgt[b]   = 32'h0;
        for (int i = 0; i < NENT; i++) begin
          m_valid[b][i] = 1'b0;
          m_ctr[b][i]   = CTR_INIT;
        end
      end else begin
        if (wb_flush)         npc = wb_alu;
        else if (ex_redirect) npc = ex_redirect_pc;
        else if (id_stall)    npc = m_pc[b];
        else if (pred)        npc = m_tgt[b][li];
        else                  npc = m_pc[b] + 32'd4;
        if (!id_stall || wb_flush || ex_redirect) begin
          m_id_pc[b]    = m_pc[b];
          m_id_sel[b]   = in_bios(m_pc[b]) ? INST_BIOS : INST_IMEM;
          m_id_valid[b] = !(wb_flush || ex_redirect);
          m_id_pt[b]    = pred;
          m_id_tgt[b]   = pred ? m_tgt[b][li] : 32'h0;
        end
        if (bp && ex_br_valid) begin
          ti   = int'((ex_br_pc / 4) % NENT);
          thit = m_valid[b][ti] && (m_tag[b][ti] == ex_br_pc / (4 * NENT));
          if (ex_br_taken) begin
            if (thit) begin
              m_ctr[b][ti] = (m_ctr[b][ti] < 3) ? m_ctr[b][ti] + 1 : 3;
            end else begin
              m_valid[b][ti] = 1'b1;
              m_tag[b][ti]   = ex_br_pc / (4 * NENT);
              m_ctr[b][ti]   = 2;
            end
            m_tgt[b][ti] = ex_br_target;
          end else if (thit) begin
            m_ctr[b][ti] = (m_ctr[b][ti] > 0) ? m_ctr[b][ti] - 1 : 0;
          end
        end
        m_pc[b] = npc;
      end
    end
  endtask

  task automatic check_model();
    chk("p_if_addr",     if_addr_p,         m_pc[0]);
    chk("p_if_bios_en",  w(if_bios_en_p),   w(in_bios(m_pc[0])));
    chk("p_id_pc",       id_pc_p,           m_id_pc[0]);
    chk("p_id_inst_sel", {30'b0, id_inst_sel_p}, {30'b0, m_id_sel[0]});
    chk("p_id_valid",    w(id_valid_p),     w(m_id_valid[0]));
    chk("p_id_pred",     w(id_pred_taken_p), w(m_id_pt[0]));
    chk("p_id_pred_tgt", id_pred_target_p,  m_id_tgt[0]);
    chk("n_if_addr",     if_addr_n,         m_pc[1]);
    chk("n_if_bios_en",  w(if_bios_en_n),   w(in_bios(m_pc[1])));
    chk("n_id_pc",       id_pc_n,           m_id_pc[1]);
    chk("n_id_inst_sel", {30'b0, id_inst_sel_n}, {30'b0, m_id_sel[1]});
    chk("n_id_valid",    w(id_valid_n),     w(m_id_valid[1]));
    chk("n_id_pred",     w(id_pred_taken_n), w(m_id_pt[1]));
    chk("n_id_pred_tgt", id_pred_target_n,  m_id_tgt[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    check_model();
  endtask

  task automatic idle();
    id_stall       = 1'b0;
    ex_redirect    = 1'b0;
    ex_redirect_pc = 32'h0;
    ex_br_valid    = 1'b0;
    ex_br_pc       = 32'h0;
    ex_br_taken    = 1'b0;
    ex_br_target   = 32'h0;
    wb_flush       = 1'b0;
    wb_alu         = 32'h0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    ex_redirect    = 1'b1;
    ex_redirect_pc = pc;
    cycle();
    ex_redirect    = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    ex_br_valid  = 1'b1;
    ex_br_pc     = pc;
    ex_br_taken  = taken;
    ex_br_target = tgt;
    cycle();
    ex_br_valid  = 1'b0;
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] a;
    a = 32'h1000_0000 + 32'($urandom_range(0, 31)) * 4;
    if ($urandom_range(0, 3) == 0) a = a + 32'h0000_1000;
    if ($urandom_range(0, 7) == 0) a = a ^ 32'h5000_0000;
    return a;
  endfunction

  initial begin
    idle();
    rst = 1'b0;
    cycle();
    cycle();
    chk("reset_if_addr",  if_addr_p,        RESET_PC);
    chk("reset_id_valid", w(id_valid_p),    32'h0);
    chk("reset_id_sel",   {30'b0, id_inst_sel_p}, {30'b0, INST_IMEM});
    rst = 1'b1;
    cycle();
    chk("seq_4",          if_addr_p,        32'h4000_0004);
    chk("first_id_valid", w(id_valid_p),    32'h1);
    chk("first_id_sel",   {30'b0, id_inst_sel_p}, {30'b0, INST_BIOS});
    cycle();
    chk("seq_8",          if_addr_p,        32'h4000_0008);

    // Allocate entry for 0x1000_0010 and fetch it.
    ex_br_valid = 1'b1; ex_br_pc = 32'h1000_0010; ex_br_taken = 1'b1;
    ex_br_target = 32'h1000_0000;
    redirect(32'h1000_0010);
    idle();
    chk("redir_if_addr",  if_addr_p,        32'h1000_0010);
    cycle();
    chk("pred_if_addr",   if_addr_p,        32'h1000_0000);
    chk("pred_taken",     w(id_pred_taken_p), 32'h1);
    chk("pred_target",    id_pred_target_p, 32'h1000_0000);
    chk("nobp_seq",       if_addr_n,        32'h1000_0014);
    chk("nobp_pred",      w(id_pred_taken_n), 32'h0);

    // Two not-taken: 2 -> 1 -> 0.
    train(32'h1000_0010, 1'b0, 32'h0);
    train(32'h1000_0010, 1'b0, 32'h0);
    redirect(32'h1000_0010);
    cycle();
    chk("nt_if_addr",     if_addr_p,        32'h1000_0014);
    chk("nt_pred",        w(id_pred_taken_p), 32'h0);

    // Four taken saturate at 3; one not-taken still predicts, two do not.
    for (int k = 0; k < 4; k++) train(32'h1000_0010, 1'b1, 32'h1000_0000);
    train(32'h1000_0010, 1'b0, 32'h0);
    redirect(32'h1000_0010);
    cycle();
    chk("sat_pred",       if_addr_p,        32'h1000_0000);
    train(32'h1000_0010, 1'b0, 32'h0);
    redirect(32'h1000_0010);
    cycle();
    chk("sat_nopred",     if_addr_p,        32'h1000_0014);

    // Alias on the same index with a different tag.
    ex_br_valid = 1'b1; ex_br_pc = 32'h1000_0010; ex_br_taken = 1'b1;
    ex_br_target = 32'h1000_0000;
    redirect(32'h1000_0050);
    idle();
    cycle();
    chk("alias_if_addr",  if_addr_p,        32'h1000_0054);
    chk("alias_pred",     w(id_pred_taken_p), 32'h0);
    redirect(32'h1000_0010);
    cycle();
    chk("alias_orig",     if_addr_p,        32'h1000_0000);

    // Stall + EX redirect + WB flush in one cycle.
    id_stall = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 32'h1000_0100;
    wb_flush = 1'b1; wb_alu = 32'h4000_0200;
    cycle();
    chk("flush_if_addr",  if_addr_p,        32'h4000_0200);
    chk("flush_id_valid", w(id_valid_p),    32'h0);
    ex_redirect = 1'b0; wb_flush = 1'b0;
    cycle();
    chk("stall_hold",     if_addr_p,        32'h4000_0200);
    idle();
    cycle();
    chk("stall_release",  if_addr_p,        32'h4000_0204);
    chk("release_id_pc",  id_pc_p,          32'h4000_0200);

    // Address wrap.
    redirect(32'hFFFF_FFFC);
    cycle();
    chk("wrap_p",         if_addr_p,        32'h0000_0000);
    chk("wrap_n",         if_addr_n,        32'h0000_0000);
    cycle();
    chk("wrap_id_sel",    {30'b0, id_inst_sel_p}, {30'b0, INST_IMEM});

    // Same-cycle lookup and training sees the old contents.
    redirect(32'h1000_0020);
    train(32'h1000_0020, 1'b1, 32'h1000_0300);
    chk("same_cyc_old",   if_addr_p,        32'h1000_0024);
    redirect(32'h1000_0020);
    cycle();
    chk("same_cyc_new",   if_addr_p,        32'h1000_0300);

    // Reset mid-operation beats a flush and training, and clears the BTB.
    rst = 1'b0; wb_flush = 1'b1; wb_alu = 32'h1000_0000;
    ex_br_valid = 1'b1; ex_br_pc = 32'h1000_0090; ex_br_taken = 1'b1;
    cycle();
    chk("midrst_if_addr", if_addr_p,        RESET_PC);
    chk("midrst_valid",   w(id_valid_p),    32'h0);
    idle();
    rst = 1'b1;
    redirect(32'h1000_0010);
    cycle();
    chk("midrst_btb_clr", if_addr_p,        32'h1000_0014);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst            = ($urandom_range(0, 99) >= 2);
      id_stall       = ($urandom_range(0, 4) == 0);
      ex_redirect    = ($urandom_range(0, 9) == 0);
      ex_redirect_pc = pick_pc();
      wb_flush       = ($urandom_range(0, 19) == 0);
      wb_alu         = pick_pc();
      ex_br_valid    = ($urandom_range(0, 2) == 0);
      ex_br_pc       = pick_pc();
      ex_br_taken    = ($urandom_range(0, 2) != 0);
      ex_br_target   = pick_pc();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
